led_pwm_blinker: RTL

LED_PWM_BLINKER -- requirements
Module: led_pwm_blinker

---
 rtl/led_pkg.sv | 17 +
 rtl/led_channel.sv | 116 +++++++++++
 rtl/led_pwm_blinker.sv | 107 ++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the LED PWM/blink controller.
//   - 2-bit per-channel mode encodings
//   - breathe FSM state type and its state constants
package led_pkg;

  // Per-channel mode encodings
  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_SOLID   = 2'b01;
  localparam logic [1:0] MODE_BLINK   = 2'b10;
  localparam logic [1:0] MODE_BREATHE = 2'b11;

  // Breathe FSM state type: ramping up or ramping down
  typedef logic [0:0] breathe_state_t;
  localparam breathe_state_t BR_UP   = 1'b0;
  localparam breathe_state_t BR_DOWN = 1'b1;

endpackage

// File: rtl/led_channel.sv
// One LED channel: OFF / SOLID / BLINK / BREATHE behaviour driven by the
// shared PWM counter and the shared prescaler tick.
// Ports:
//   clk, rst  : clock and asynchronous active-high reset
//   enable    : 1 = run, 0 = hold all state and drive led low
//   tick      : one-cycle prescaler pulse (already qualified with enable)
//   mode      : channel mode (led_pkg MODE_* encodings)
//   duty      : SOLID-mode duty value
//   pwm_cnt   : shared free-running PWM counter
//   led       : registered LED drive
module led_channel
  import led_pkg::*;
#(
  parameter int unsigned PWM_W      = 8,
  parameter int unsigned BLINK_HALF = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             tick,
  input  logic [1:0]       mode,
  input  logic [PWM_W-1:0] duty,
  input  logic [PWM_W-1:0] pwm_cnt,
  output logic             led
);

  localparam int unsigned     TC_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [TC_W-1:0] TC_LAST = TC_W'(BLINK_HALF - 1);
  localparam logic [PWM_W-1:0] LVL_MAX = '1;

  logic [1:0]       prev_mode, prev_mode_next;
  logic [TC_W-1:0]  tick_cnt, tick_cnt_next;
  logic             blink_state, blink_next;
  logic [PWM_W-1:0] level, level_next;
  breathe_state_t   br_state, br_next;
  logic             led_next;
  logic             mode_chg_c;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_mode   <= MODE_OFF;
      tick_cnt    <= '0;
      blink_state <= 1'b0;
      level       <= '0;
      br_state    <= BR_UP;
      led         <= 1'b0;
    end else begin
      prev_mode   <= prev_mode_next;
      tick_cnt    <= tick_cnt_next;
      blink_state <= blink_next;
      level       <= level_next;
      br_state    <= br_next;
      led         <= led_next;
    end
  end

  // Next-state and LED decode; a mode change takes priority over a tick
  always_comb begin
    prev_mode_next = prev_mode;
    tick_cnt_next  = tick_cnt;
    blink_next     = blink_state;
    level_next     = level;
    br_next        = br_state;
    led_next       = 1'b0;
    mode_chg_c     = (mode != prev_mode);

    if (enable) begin
      prev_mode_next = mode;
      if (mode_chg_c) begin
        tick_cnt_next = '0;
        blink_next    = 1'b0;
        level_next    = '0;
        br_next       = BR_UP;
      end else begin
        if (tick) begin
          if (mode == MODE_BLINK) begin
            if (tick_cnt == TC_LAST) begin
              tick_cnt_next = '0;
              blink_next    = ~blink_state;
            end else begin
              tick_cnt_next = TC_W'(tick_cnt + 1'b1);
            end
          end else if (mode == MODE_BREATHE) begin
            case (br_state)
              BR_UP: begin
                if (level == LVL_MAX) begin
                  br_next    = BR_DOWN;
                  level_next = PWM_W'(LVL_MAX - 1'b1);
                end else begin
                  level_next = PWM_W'(level + 1'b1);
                end
              end
              default: begin
                if (level == '0) begin
                  br_next    = BR_UP;
                  level_next = PWM_W'(1);
                end else begin
                  level_next = PWM_W'(level - 1'b1);
                end
              end
            endcase
          end
        end

        case (mode)
          MODE_SOLID:   led_next = (pwm_cnt < duty);
          MODE_BLINK:   led_next = blink_state;
          MODE_BREATHE: led_next = (pwm_cnt < level);
          default:      led_next = 1'b0;
        endcase
      end
    end
  end

endmodule

// File: rtl/led_pwm_blinker.sv
// Multi-channel LED controller: shared prescaler and PWM counter feeding
// N_CH independent channels (OFF / SOLID / BLINK / BREATHE).
// Ports:
//   WB_CLK : fabric clock
//   WB_RST : asynchronous active-high reset (release synchronised internally)
//   enable : 1 = run, 0 = freeze every counter and force outputs low
//   mode   : 2 bits per channel, channel i at [2i+1:2i]
//   duty   : PWM_W bits per channel, channel i at [PWM_W*i +: PWM_W]
//   led    : registered LED drive, one bit per channel
//   tick   : registered one-cycle pulse per prescaler period
module led_pwm_blinker
  import led_pkg::*;
#(
  parameter int unsigned N_CH       = 3,
  parameter int unsigned PWM_W      = 8,
  parameter int unsigned PRESC_DIV  = 50000,
  parameter int unsigned BLINK_HALF = 256
) (
  input  logic                    WB_CLK,
  input  logic                    WB_RST,
  input  logic                    enable,
  input  logic [2*N_CH-1:0]       mode,
  input  logic [PWM_W*N_CH-1:0]   duty,
  output logic [N_CH-1:0]         led,
  output logic                    tick
);

  // Reject unusable configurations at elaboration
  if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
    $fatal(1, "led_pwm_blinker: N_CH must be in 1..16");
  end
  if (PRESC_DIV < 2) begin : g_bad_presc
    $fatal(1, "led_pwm_blinker: PRESC_DIV must be >= 2");
  end
  if (BLINK_HALF < 1) begin : g_bad_blink
    $fatal(1, "led_pwm_blinker: BLINK_HALF must be >= 1");
  end

  localparam int unsigned     PS_W    = $clog2(PRESC_DIV);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESC_DIV - 1);

  logic             rst_meta, rst_sync;
  logic [PS_W-1:0]  presc, presc_next;
  logic [PWM_W-1:0] pwm_cnt, pwm_next;
  logic             tick_next;
  logic             ch_tick_c;

  // Reset asserts immediately, releases two clock edges after WB_RST falls
  always_ff @(posedge WB_CLK or posedge WB_RST) begin
    if (WB_RST) begin
      rst_meta <= 1'b1;
      rst_sync <= 1'b1;
    end else begin
      rst_meta <= 1'b0;
      rst_sync <= rst_meta;
    end
  end

  // Shared prescaler / PWM counter registers
  always_ff @(posedge WB_CLK or posedge rst_sync) begin
    if (rst_sync) begin
      presc   <= '0;
      pwm_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      presc   <= presc_next;
      pwm_cnt <= pwm_next;
      tick    <= tick_next;
    end
  end

  // Counters advance only while enabled; tick marks the prescaler wrap
  always_comb begin
    presc_next = presc;
    pwm_next   = pwm_cnt;
    tick_next  = 1'b0;
    if (enable) begin
      pwm_next = PWM_W'(pwm_cnt + 1'b1);
      if (presc == PS_LAST) begin
        presc_next = '0;
        tick_next  = 1'b1;
      end else begin
        presc_next = PS_W'(presc + 1'b1);
      end
    end
  end

  // A pending tick is not consumed by channels while disabled
  assign ch_tick_c = tick & enable;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    led_channel #(
      .PWM_W      (PWM_W),
      .BLINK_HALF (BLINK_HALF)
    ) u_ch (
      .clk     (WB_CLK),
      .rst     (rst_sync),
      .enable  (enable),
      .tick    (ch_tick_c),
      .mode    (mode[2*i +: 2]),
      .duty    (duty[PWM_W*i +: PWM_W]),
      .pwm_cnt (pwm_cnt),
      .led     (led[i])
    );
  end

endmodule
